// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND,
    HALT
  } fetch_state_t;

  // Byte distance between consecutive word-aligned fetches.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-control bundle.
// master: branch unit / hazard unit / imem side.
// slave: the fetch redirect controller.
interface fetch_redirect_ctrl_if #(
  parameter int PW    = 9,
  parameter int CNT_W = 16
);

  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             stall_i;
  logic             imem_ready_i;
  logic [PW-1:0]    pc_o;
  logic             fetch_valid_o;
  logic             if_id_en_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             halted_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  modport master (
    output redirect_i, redirect_pc_i, stall_i, imem_ready_i,
    input  pc_o, fetch_valid_o, if_id_en_o, if_id_flush_o, id_ex_flush_o,
           halted_o, redirect_cnt_o
  );

  modport slave (
    input  redirect_i, redirect_pc_i, stall_i, imem_ready_i,
    output pc_o, fetch_valid_o, if_id_en_o, if_id_flush_o, id_ex_flush_o,
           halted_o, redirect_cnt_o
  );

endinterface

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count increments until the counter is full, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: sequences branch redirects, stalls and imem back-pressure,
// halts on an unreachable or misaligned redirect target.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int            PW       = 9,
  parameter logic [PW-1:0] RESET_PC = '0,
  parameter int            CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  fetch_redirect_ctrl_if.slave bus
);

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] pend_pc_q, pend_pc_d;
  logic          bad_target;
  logic          cnt_inc;
  logic          fetch_valid, if_id_en, if_id_flush, id_ex_flush, halted;

  // A target is unusable if it is not word aligned or lies beyond the PC range.
  assign bad_target = (bus.redirect_pc_i[1:0] != 2'b00) ||
                      ((bus.redirect_pc_i >> PW) != 32'd0);

  // State, fetch PC and parked redirect target registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state, next-PC and pipeline control decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    fetch_valid = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        fetch_valid = 1'b1;
        if (bus.redirect_i && bad_target) begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = HALT;
        end else if (bus.redirect_i) begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_inc     = 1'b1;
          if (bus.imem_ready_i) begin
            pc_d = bus.redirect_pc_i[PW-1:0];
          end else begin
            pend_pc_d = bus.redirect_pc_i[PW-1:0];
            state_d   = PEND;
          end
        end else if (!bus.stall_i && bus.imem_ready_i) begin
          if_id_en = 1'b1;
          pc_d     = pc_q + PW'(PC_STEP);
        end
      end
      PEND: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (bus.imem_ready_i) begin
          pc_d    = pend_pc_q;
          state_d = RUN;
        end
      end
      HALT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .cnt   (bus.redirect_cnt_o)
  );

  assign bus.pc_o          = pc_q;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.if_id_en_o    = if_id_en;
  assign bus.if_id_flush_o = if_id_flush;
  assign bus.id_ex_flush_o = id_ex_flush;
  assign bus.halted_o      = halted;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: a wide-counter and a 2-bit-counter
// instance share one stimulus stream; a reference model queues expected outputs.
module tb_fetch_redirect_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int PW = 9;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic          valid;
    logic          en;
    logic          if_flush;
    logic          ex_flush;
    logic          halted;
    logic [15:0]   cnt;
    logic [1:0]    cnt_small;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic        stall = 1'b0;
  logic        ready = 1'b0;

  int checks = 0;
  int errors = 0;
  obs_t sb[$];

  fetch_state_t  m_state;
  logic [PW-1:0] m_pc;
  logic [PW-1:0] m_pend;
  int            m_cnt;
  int            m_cnt_small;

  always #5 clk = ~clk;

  fetch_redirect_ctrl_if #(.PW(PW), .CNT_W(16)) bus ();
  fetch_redirect_ctrl_if #(.PW(PW), .CNT_W(2))  bus_small ();

  assign bus.redirect_i          = redirect;
  assign bus.redirect_pc_i       = target;
  assign bus.stall_i             = stall;
  assign bus.imem_ready_i        = ready;
  assign bus_small.redirect_i    = redirect;
  assign bus_small.redirect_pc_i = target;
  assign bus_small.stall_i       = stall;
  assign bus_small.imem_ready_i  = ready;

  fetch_redirect_ctrl #(.PW(PW), .RESET_PC(9'h000), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  fetch_redirect_ctrl #(.PW(PW), .RESET_PC(9'h000), .CNT_W(2)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_small.slave)
  );

  function automatic obs_t sample();
    obs_t o;
    o.pc        = bus.pc_o;
    o.valid     = bus.fetch_valid_o;
    o.en        = bus.if_id_en_o;
    o.if_flush  = bus.if_id_flush_o;
    o.ex_flush  = bus.id_ex_flush_o;
    o.halted    = bus.halted_o;
    o.cnt       = bus.redirect_cnt_o;
    o.cnt_small = bus_small.redirect_cnt_o;
    return o;
  endfunction

  task automatic model_reset();
    m_state     = BOOT;
    m_pc        = '0;
    m_pend      = '0;
    m_cnt       = 0;
    m_cnt_small = 0;
  endtask

  // Drive one cycle of inputs, queue the model's view of this cycle, wait for mid-cycle.
  task automatic drive(input logic r, input logic [31:0] t, input logic s, input logic rdy);
    obs_t e;
    logic bad;
    redirect = r;
    target   = t;
    stall    = s;
    ready    = rdy;
    e = '0;
    e.pc        = m_pc;
    e.cnt       = 16'(m_cnt);
    e.cnt_small = 2'(m_cnt_small);
    bad = r && ((t[1:0] != 2'b00) || (t >= 32'(1 << PW)));
    case (m_state)
      BOOT: m_state = RUN;
      RUN: begin
        e.valid = 1'b1;
        if (bad) begin
          e.en = 1'b1; e.if_flush = 1'b1; e.ex_flush = 1'b1;
          m_state = HALT;
        end else if (r) begin
          e.en = 1'b1; e.if_flush = 1'b1; e.ex_flush = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_small < 3) m_cnt_small++;
          if (rdy) m_pc = t[PW-1:0];
          else begin
            m_pend  = t[PW-1:0];
            m_state = PEND;
          end
        end else if (!s && rdy) begin
          e.en = 1'b1;
          m_pc = PW'((int'(m_pc) + 4) % (1 << PW));
        end
      end
      PEND: begin
        e.if_flush = 1'b1; e.ex_flush = 1'b1;
        if (rdy) begin
          m_pc    = m_pend;
          m_state = RUN;
        end
      end
      HALT: begin
        e.if_flush = 1'b1; e.ex_flush = 1'b1; e.halted = 1'b1;
      end
      default: m_state = BOOT;
    endcase
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Reset held across one rising edge, released 1 time unit after it.
  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, a;
    logic [PW-1:0] want_pc [4] = '{9'h000, 9'h000, 9'h004, 9'h008};
    #1 rst_n = 1'b0;
    model_reset();
    e = '0;
    sb.push_back(e);
    #2;
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL reset_state: got %h, want %h", a, e); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL boot_seq[%0d]: got %h, want %h", i, a, e); end
      checks++;
      if (a.pc !== want_pc[i] || a.valid !== (i > 0)) begin
        errors++;
        $display("[TB] FAIL boot_pc[%0d]: got pc=%h valid=%b, want pc=%h valid=%b", i, a.pc, a.valid, want_pc[i], (i > 0));
      end
      next_edge();
    end
  endtask

  task automatic test_redirect_with_stall();
    obs_t e, a;
    for (int i = 0; i < 8 && m_pc != 9'h010; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL walk_to_10[%0d]: got %h, want %h", i, a, e); end
      next_edge();
    end
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e || a.pc !== 9'h010 || a.if_flush !== 1'b1 || a.ex_flush !== 1'b1) begin
      errors++; $display("[TB] FAIL redirect_stall_flush: got %h, want %h (pc 010, both flushes)", a, e);
    end
    next_edge();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e || a.pc !== 9'h040 || a.cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL redirect_target: got %h, want %h (pc 040, cnt 1)", a, e);
    end
    next_edge();
  endtask

  task automatic test_pending_redirect();
    obs_t e, a;
    logic [PW-1:0] held_pc;
    logic r_t [6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic rdy_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    held_pc = m_pc;
    for (int i = 0; i < 6; i++) begin
      drive(r_t[i], (i == 0) ? 32'h80 : 32'h3, 1'b1, rdy_t[i]);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL pend_seq[%0d]: got %h, want %h", i, a, e); end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (a.pc !== held_pc || a.valid !== 1'b0 || a.if_flush !== 1'b1 || a.ex_flush !== 1'b1) begin
          errors++; $display("[TB] FAIL pend_hold[%0d]: got pc=%h valid=%b flush=%b%b, want pc=%h valid=0 flush=11",
                             i, a.pc, a.valid, a.if_flush, a.ex_flush, held_pc);
        end
      end
      if (i == 5) begin
        checks++;
        if (a.pc !== 9'h080 || a.valid !== 1'b1) begin
          errors++; $display("[TB] FAIL pend_release: got pc=%h valid=%b, want pc=080 valid=1", a.pc, a.valid);
        end
      end
      next_edge();
    end
  endtask

  task automatic test_bad_target();
    obs_t e, a;
    logic [31:0] bad_t [2] = '{32'h42, 32'h200};
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      for (int i = 0; i < 6; i++) begin
        case (i)
          0, 1:    drive(1'b0, 32'h0, 1'b0, 1'b1);
          2:       drive(1'b1, bad_t[k], 1'b0, 1'b1);
          default: drive(1'b1, 32'h40, 1'b0, 1'b1);
        endcase
        e = sb.pop_front(); a = sample(); checks++;
        if (a !== e) begin errors++; $display("[TB] FAIL bad_target_%0d[%0d]: got %h, want %h", k, i, a, e); end
        if (i >= 3) begin
          checks++;
          if (a.halted !== 1'b1 || a.pc !== 9'h004 || a.cnt !== 16'd0 || a.valid !== 1'b0 || a.en !== 1'b0) begin
            errors++; $display("[TB] FAIL halt_frozen_%0d[%0d]: got %h, want halted pc=004 cnt=0", k, i, a);
          end
        end
        next_edge();
      end
    end
    apply_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e || a.halted !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_cleared: got %h, want %h", a, e);
    end
    next_edge();
  endtask

  task automatic test_wrap_and_stall();
    obs_t e, a;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       drive(1'b1, 32'h1FC, 1'b0, 1'b1);
        1, 5:    drive(1'b0, 32'h0, 1'b0, 1'b1);
        default: drive(1'b0, 32'h0, 1'b1, 1'b1);
      endcase
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL wrap_stall[%0d]: got %h, want %h", i, a, e); end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (a.pc !== 9'h000 || a.en !== 1'b0 || a.if_flush !== 1'b0) begin
          errors++; $display("[TB] FAIL wrap_hold[%0d]: got pc=%h en=%b flush=%b, want pc=000 en=0 flush=0", i, a.pc, a.en, a.if_flush);
        end
      end
      next_edge();
    end
  endtask

  task automatic test_saturation_and_reset();
    obs_t e, a;
    logic [1:0] want_small [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i >= 1 && i <= 5) drive(1'b1, 32'(16 + 4 * i), 1'b0, 1'b1);
      else if (i == 6)      drive(1'b1, 32'h0C0, 1'b0, 1'b0);
      else                  drive(1'b0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL sat_seq[%0d]: got %h, want %h", i, a, e); end
      if (i >= 2 && i <= 6) begin
        checks++;
        if (a.cnt_small !== want_small[i-2] || a.cnt !== 16'(i - 1)) begin
          errors++; $display("[TB] FAIL sat_cnt[%0d]: got small=%0d wide=%0d, want small=%0d wide=%0d",
                             i, a.cnt_small, a.cnt, want_small[i-2], i - 1);
        end
      end
      next_edge();
    end
    rst_n = 1'b0;
    model_reset();
    e = '0;
    sb.push_back(e);
    #2;
    e = sb.pop_front(); a = sample(); checks++;
    if (a !== e) begin errors++; $display("[TB] FAIL reset_mid_pend: got %h, want %h", a, e); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || a.pc !== 9'h000) begin
        errors++; $display("[TB] FAIL post_reset[%0d]: got %h, want %h (pc 000)", i, a, e);
      end
      next_edge();
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    logic        r, s, rdy;
    logic [31:0] t;
    for (int i = 0; i < 80; i++) begin
      if (m_state == HALT) apply_reset();
      r   = ($urandom_range(0, 2) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      t   = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      if ($urandom_range(0, 15) == 0) t = t | 32'h201;
      drive(r, t, s, rdy);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin errors++; $display("[TB] FAIL random[%0d]: got %h, want %h", i, a, e); end
      next_edge();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_redirect_with_stall();
    test_pending_redirect();
    test_bad_target();
    test_wrap_and_stall();
    test_saturation_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
